// File: rtl/mxdp_pkg.sv
// Shared limits and helpers for the N:1 datapath mux pipeline.
package mxdp_pkg;

   localparam int N_MIN   = 2;
   localparam int N_MAX   = 16;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   // Control bits that travel alongside each sample's data word
   typedef struct packed {
      logic v;
      logic err;
   } stg_flags_t;

   localparam int FLAG_W = $bits(stg_flags_t);

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int stage_width(input int w);
      return w + FLAG_W;
   endfunction

endpackage

// File: rtl/mxdp_stage.sv
// One pipeline register of {v, err, data}.
// Data only loads when a valid sample arrives, so bubbles and flushes keep the last word.
module mxdp_stage
   import mxdp_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         stall_i,
   input  logic         v_i,
   input  logic         err_i,
   input  logic [W-1:0] data_i,
   output logic         v_o,
   output logic         err_o,
   output logic [W-1:0] data_o
);

   stg_flags_t   flags_q, flags_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      flags_d = flags_q;
      data_d  = data_q;
      if (flush_i) begin
         flags_d = '0;
      end else if (!stall_i) begin
         flags_d.v   = v_i;
         flags_d.err = v_i & err_i;
         if (v_i) data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
         data_q  <= '0;
      end else begin
         flags_q <= flags_d;
         data_q  <= data_d;
      end
   end

   assign v_o    = flags_q.v;
   assign err_o  = flags_q.err;
   assign data_o = data_q;

endmodule

// File: rtl/mxdp_pipe.sv
// N:1 datapath select with range check, followed by a LAT-deep register chain
// carrying valid and select-error alongside the data.
module mxdp_pipe
   import mxdp_pkg::*;
#(
   parameter  int W     = 32,
   parameter  int N     = 4,
   parameter  int LAT   = 1,
   localparam int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   din,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [W-1:0]     dout,
   output logic             sel_err
);

   if (N < N_MIN || N > N_MAX || LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_cfg
      $fatal(1, "mxdp_pipe: N or LAT out of supported range");
   end

   logic [W-1:0] mux_data;
   logic         mux_err;

   // Out-of-range selects yield zero data and flag the error with the sample
   always_comb begin
      mux_data = '0;
      mux_err  = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (int'(sel) == k) begin
            mux_data = din[k*W +: W];
            mux_err  = 1'b0;
         end
      end
   end

   logic [LAT-1:0]        v_c;
   logic [LAT-1:0]        err_c;
   logic [LAT-1:0][W-1:0] data_c;

   for (genvar i = 0; i < LAT; i++) begin : g_stage
      logic         v_in;
      logic         err_in;
      logic [W-1:0] data_in;

      if (i == 0) begin : g_head
         assign v_in    = in_valid;
         assign err_in  = mux_err;
         assign data_in = mux_data;
      end else begin : g_link
         assign v_in    = v_c[i-1];
         assign err_in  = err_c[i-1];
         assign data_in = data_c[i-1];
      end

      mxdp_stage #(.W(W)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .stall_i (stall),
         .v_i     (v_in),
         .err_i   (err_in),
         .data_i  (data_in),
         .v_o     (v_c[i]),
         .err_o   (err_c[i]),
         .data_o  (data_c[i])
      );
   end

   assign out_valid = v_c[LAT-1];
   assign sel_err   = err_c[LAT-1];
   assign dout      = data_c[LAT-1];

endmodule

// File: tb/tb_mxdp_pipe.sv
// Directed plus randomized checks of mxdp_pipe (N=3, LAT=3) against a cycle model.
module tb_mxdp_pipe;

   localparam int W   = 32;
   localparam int N   = 3;
   localparam int LAT = 3;
   localparam int SW  = 2;

   logic           clk = 1'b0;
   logic           rst, in_valid, stall, flush;
   logic [SW-1:0]  sel;
   logic [N*W-1:0] din;
   logic           out_valid, sel_err;
   logic [W-1:0]   dout;

   int checks = 0;
   int errors = 0;

   logic         mv [LAT];
   logic         me [LAT];
   logic [W-1:0] md [LAT];

   always #5 clk = ~clk;

   mxdp_pipe #(.W(W), .N(N), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .sel       (sel),
      .din       (din),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .dout      (dout),
      .sel_err   (sel_err)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: the pipe as an array of LAT slots moved by the cycle rules
   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            mv[i] = 1'b0; me[i] = 1'b0; md[i] = '0;
         end
      end else if (flush) begin
         for (int i = 0; i < LAT; i++) begin
            mv[i] = 1'b0; me[i] = 1'b0;
         end
      end else if (!stall) begin
         for (int i = LAT-1; i > 0; i--) begin
            mv[i] = mv[i-1];
            if (mv[i-1]) begin
               me[i] = me[i-1]; md[i] = md[i-1];
            end else begin
               me[i] = 1'b0;
            end
         end
         mv[0] = in_valid;
         if (in_valid) begin
            me[0] = (int'(sel) >= N);
            md[0] = (int'(sel) < N) ? din[int'(sel)*W +: W] : '0;
         end else begin
            me[0] = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("out_valid", W'(out_valid), W'(mv[LAT-1]));
      chk("sel_err",   W'(sel_err),   W'(me[LAT-1]));
      chk("dout",      dout,          md[LAT-1]);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; sel = '0; din = '0;

      step(); step();
      chk("rst_valid", W'(out_valid), '0);
      chk("rst_dout",  dout,          '0);
      chk("rst_err",   W'(sel_err),   '0);
      rst = 1'b0;

      // Stream lanes 0..2
      din = {32'h33, 32'h22, 32'h11};
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1; sel = SW'(k);
         step();
      end
      in_valid = 1'b0;
      chk("stream_first", dout, 32'h11);
      step(); chk("stream_second", dout, 32'h22);
      step(); chk("stream_third",  dout, 32'h33);
      step();

      // Out-of-range select, then a good one
      din = {$urandom, $urandom, $urandom};
      in_valid = 1'b1; sel = 2'd3;
      step();
      in_valid = 1'b0;
      step(); step();
      chk("oor_valid", W'(out_valid), 32'd1);
      chk("oor_err",   W'(sel_err),   32'd1);
      chk("oor_dout",  dout,          '0);
      in_valid = 1'b1; sel = 2'd2;
      step();
      in_valid = 1'b0;
      step(); step();
      chk("ok_err",  W'(sel_err), '0);
      chk("ok_dout", dout,        din[2*W +: W]);

      // Stall for 4 cycles mid-stream
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; sel = SW'(k % N); din = {$urandom, $urandom, $urandom};
         step();
         if (k == 2) begin
            stall = 1'b1;
            repeat (4) step();
            stall = 1'b0;
         end
      end
      in_valid = 1'b0;
      repeat (LAT) step();

      // Flush together with stall, two samples in flight
      in_valid = 1'b1; sel = 2'd0; din = {$urandom, $urandom, $urandom};
      step(); step();
      flush = 1'b1; stall = 1'b1; sel = 2'd1; din[W +: W] = 32'hBADC0DE5;
      step();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      chk("flush_valid", W'(out_valid), '0);
      repeat (LAT + 1) step();

      // Bubbles on lane 1
      sel = 2'd1; din[W +: W] = 32'hDEADBEEF;
      in_valid = 1'b1; step();
      in_valid = 1'b0; step();
      din[W +: W] = 32'hCAFEF00D;
      in_valid = 1'b1; step();
      in_valid = 1'b0;
      chk("bubble_hold_a", dout, 32'hDEADBEEF);
      step(); chk("bubble_hold_b", dout, 32'hDEADBEEF);
      step(); chk("bubble_new",    dout, 32'hCAFEF00D);
      repeat (2) step();

      // Reset with the pipe full
      for (int k = 0; k < LAT; k++) begin
         in_valid = 1'b1; sel = SW'($urandom_range(0, N-1)); din = {$urandom, $urandom, $urandom};
         step();
      end
      rst = 1'b1; step();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_valid", W'(out_valid), '0);
      chk("mid_rst_dout",  dout,          '0);
      repeat (LAT + 1) step();

      // Randomized traffic
      for (int c = 0; c < 500; c++) begin
         rst      = ($urandom_range(0, 63) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         stall    = ($urandom_range(0, 4) == 0);
         in_valid = $urandom_range(0, 1);
         sel      = SW'($urandom_range(0, 3));
         din      = {$urandom, $urandom, $urandom};
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mxdp_pipe.md
# mxdp_pipe

Parametrised N:1 datapath multiplexer with a configurable-depth registered output pipeline, stall and flush control. It generalises the 2:1 combinational datapath select to N inputs of W bits. It also carries a valid bit and a select-error flag down the pipe. It sits between pipeline stages of the processor datapath, for example operand and forwarding selection ahead of the ALU, where the select must align with the stage registers.

## Interface
- W, 32, data width per input
- N, 4, number of inputs (2..16)
- LAT, 1, register stages between input and output (1..4)
- SEL_W, derived = max(1, ceil(log2(N))), select width (localparam, not overridable)

- clk  in  1  rising-edge clock; one clock; every register updates on clk
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid this cycle
- sel  in  SEL_W  input index; 0 selects lane 0
- din  in  N*W  packed inputs; lane k = din[k*W +: W]
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- out_valid  out  1  dout/sel_err valid
- dout  out  W  selected data after LAT cycles
- sel_err  out  1  sample had sel >= N

## Operation
- Each stage i (0..LAT-1) holds {v, err, data}. Stage 0 is fed from the mux. Stage i is fed from stage i-1. Outputs come from stage LAT-1.
- Mux, combinational: if sel < N then mux_data = lane[sel] and mux_err = 0. Otherwise mux_data = 0 and mux_err = 1. When N is a power of two, mux_err is constant 0.
- Per-cycle priority: rst > flush > stall > advance.
  - rst: all v, err and data cleared to 0.
  - flush (no rst): all v and err cleared to 0. data is held. The input sample of that cycle is discarded. Flush overrides stall.
  - stall (no rst, no flush): every stage holds v, err and data. The input is not sampled. The upstream source must hold in_valid/sel/din itself.
  - advance: each stage takes its predecessor's v. err and data load only when the incoming v = 1. A bubble (v = 0) propagates v = 0 and err = 0, and data holds its old value.
- err of a sample travels with it. sel_err is asserted only together with out_valid.
- No internal state machine beyond the valid shift chain. Occupancy is implicit (0..LAT valid samples in flight).

## Timing
- Reset values: out_valid = 0, sel_err = 0, dout = 0, all internal stages 0.
- Latency: a sample accepted at edge t (in_valid = 1, stall = 0, flush = 0) appears at out_valid/dout after edge t+LAT-1. It is visible for LAT cycles counted from acceptance, plus any stall cycles.
- Throughput: 1 sample per cycle when stall = 0.
- Stall for k cycles: outputs remain constant for k cycles, and no sample is lost or duplicated.
- Simultaneous stall and flush: flush wins. Outputs go invalid on the next cycle.
- Reset mid-stream: all in-flight samples are lost. out_valid = 0 on the cycle after rst is sampled high.
- Width rule: dout is exactly W bits, with no sign or zero extension. sel is compared as unsigned against N.

## Structure
- Package mxdp_pkg:
  - function sel_width(n), returning max(1, ceil(log2(n)))
  - limits N_MIN = 2, N_MAX = 16, LAT_MIN = 1, LAT_MAX = 4
  - packed stage struct {v, err, data[W]}, or an equivalent parametrised width constant
- Sub-module mxdp_stage: one {v, err, data} register with rst/flush/stall/load-enable logic. It is instantiated LAT times with a generate loop.
- The top-level module holds the N:1 mux, the range check and the stage chain.
- Elaboration-time check: out-of-range N or LAT is a fatal error.

## Test plan
- Reset, then stream: rst 2 cycles, then with N=4, LAT=2, inputs lanes 0..3 = 0x11,0x22,0x33,0x44 and sel = 0,1,2,3 on consecutive cycles -> out_valid from cycle 2, dout = 0x11,0x22,0x33,0x44, sel_err = 0.
- Out-of-range select: N=3, LAT=1, sel=3, in_valid=1 -> next cycle out_valid=1, dout=0, sel_err=1. A following sel=2 sample clears sel_err.
- Stall: LAT=3, stream samples A,B,C, then stall for 4 cycles mid-stream -> outputs frozen for 4 cycles, then the sequence continues in order with no loss or duplicate.
- Flush with stall: two samples in flight, assert flush and stall together -> out_valid=0 next cycle. dout holds its last value. The sample presented in the flush cycle never appears.
- Bubbles: alternate in_valid 1/0 with sel=1 and lane 1 = 0xDEADBEEF, 0xCAFEF00D -> out_valid toggles. dout holds 0xDEADBEEF across the bubble, then changes to 0xCAFEF00D.
- Reset mid-stream: rst pulsed with LAT=4 full -> out_valid=0, dout=0 after one cycle, and no stale sample emerges afterward.
